// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch front end owning the PC, one-outstanding imem fetch,
// one-entry IF/ID output buffer, and redirect squash of in-flight fetches.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);
    typedef enum logic [1:0] {ISSUE, WAIT, DROP} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, r_req_pc, r_if_pc, r_if_inst;
    logic        r_if_valid;
    logic        w_fire, w_load;

    // Issue only when the buffer is empty or draining this cycle, so a response always finds room.
    assign imem_req_valid = rstn & (r_state == ISSUE) & ~redirect & (~r_if_valid | if_ready);
    assign imem_req_addr  = r_pc;
    assign w_fire         = imem_req_valid & imem_req_ready;
    assign w_load         = (r_state == WAIT) & imem_rsp_valid & ~redirect;
    assign if_valid       = r_if_valid;
    assign if_pc          = r_if_pc;
    assign if_inst        = r_if_inst;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ISSUE:   w_state_nxt = w_fire ? WAIT : ISSUE;
            WAIT:    w_state_nxt = imem_rsp_valid ? ISSUE : (redirect ? DROP : WAIT);
            DROP:    w_state_nxt = imem_rsp_valid ? ISSUE : DROP;
            default: w_state_nxt = ISSUE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ISSUE;
            r_pc       <= RESET_PC;
            r_req_pc   <= '0;
            r_if_valid <= 1'b0;
            r_if_pc    <= '0;
            r_if_inst  <= NOP_INST;
        end else begin
            r_state <= w_state_nxt;
            if (redirect)
                r_pc <= {redirect_pc[31:2], 2'b00};
            else if (w_fire)
                r_pc <= r_pc + 32'd4;
            if (w_fire)
                r_req_pc <= r_pc;
            if (w_load) begin
                r_if_valid <= 1'b1;
                r_if_pc    <= r_req_pc;
                r_if_inst  <= imem_rsp_data;
            end else if (redirect || (r_if_valid && if_ready)) begin
                r_if_valid <= 1'b0;
                r_if_inst  <= NOP_INST;
            end
        end
    end
endmodule
